// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the
// FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake and FIFO write
// port bundle of the write arbiter.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic                      full;
  logic [NUM_REQ-1:0]        gnt;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_wr_data;
  logic [IW-1:0]             owner;
  logic                      busy;

  modport master (
    input  req,
    input  req_data,
    input  req_last,
    input  full,
    output gnt,
    output fifo_wr_en,
    output fifo_wr_data,
    output owner,
    output busy
  );

  modport slave (
    output req,
    output req_data,
    output req_last,
    output full,
    input  gnt,
    input  fifo_wr_en,
    input  fifo_wr_data,
    input  owner,
    input  busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first
// set req bit above last_owner, with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_owner,
  output logic [IW-1:0] idx,
  output logic          vld
);

  logic [IW-1:0] j;

  // Scan farthest first so the nearest hit wins.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    j   = '0;
    for (int i = N; i >= 1; i--) begin
      j = IW'((int'(last_owner) + i) % N);
      if (req[j]) begin
        idx = j;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter driving
// the single async-FIFO write port.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input logic               wr_clk,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [IW-1:0] LAST_RST =
    IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(MAX_BURST);

  arb_state_e state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;
  logic          xfer;
  logic [NUM_REQ-1:0] gnt;
  logic [DATA_W-1:0]  wr_data;

  rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req        (bus.req),
    .last_owner (last_q),
    .idx        (pick_idx),
    .vld        (pick_vld)
  );

  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    xfer    = 1'b0;
    gnt     = '0;
    wr_data = bus.req_data[
      int'(owner_q) * DATA_W +: DATA_W];
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        xfer = bus.req[owner_q] & ~bus.full;
        if (xfer) begin
          gnt[owner_q] = 1'b1;
          cnt_d        = cnt_inc;
        end
        // Withdrawal ends the burst even while stalled.
        if (!bus.req[owner_q] ||
            (xfer && (bus.req_last[owner_q] ||
                      cnt_inc == CNT_MAX))) begin
          last_d  = owner_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign bus.gnt          = gnt;
  assign bus.fifo_wr_en   = xfer;
  assign bus.fifo_wr_data = wr_data;
  assign bus.owner        = owner_q;
  assign bus.busy         = (state_q == ARB_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random-soak checks for the
// FIFO write-port arbiter.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int BOUND = (N - 1) * (MB + 1);

  logic wr_clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter_if #(
    .NUM_REQ (N),
    .DATA_W  (DW)
  ) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .wr_clk (wr_clk),
    .rst    (rst),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic set_data(input int i,
                          input logic [DW-1:0] d);
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic clear_inputs();
    bus.req      = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    bus.full     = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #4;
    total_cnt++;
    if ({bus.gnt, bus.fifo_wr_en, bus.busy,
         bus.owner} !== '0)
      $display("FAIL reset_outputs: got gnt=%b en=%b busy=%b owner=%0d want all 0",
               bus.gnt, bus.fifo_wr_en,
               bus.busy, bus.owner);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_single();
    logic [0:9] en_t   = 10'b0111101100;
    logic [0:9] busy_t = 10'b0111101110;
    int w = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      bus.req = (w < 6) ? 4'b0100 : 4'b0000;
      set_data(2, 8'(8'hA0 + w));
      #4;
      total_cnt++;
      if ({bus.gnt, bus.fifo_wr_en, bus.busy} !==
          {(en_t[c] ? 4'b0100 : 4'b0000),
           en_t[c], busy_t[c]})
        $display("FAIL single_c%0d: got gnt=%b en=%b busy=%b want en=%b busy=%b",
                 c, bus.gnt, bus.fifo_wr_en,
                 bus.busy, en_t[c], busy_t[c]);
      else pass_cnt++;
      if (en_t[c]) begin
        total_cnt++;
        if (bus.fifo_wr_data !== 8'(8'hA0 + w))
          $display("FAIL single_data_c%0d: got %h want %h",
                   c, bus.fifo_wr_data,
                   8'(8'hA0 + w));
        else pass_cnt++;
      end
      if (c > 0) begin
        total_cnt++;
        if (bus.owner !== 2'd2)
          $display("FAIL single_owner_c%0d: got %0d want 2",
                   c, bus.owner);
        else pass_cnt++;
      end
      tick();
      if (en_t[c]) w++;
    end
  endtask

  task automatic test_all_four();
    int eo[10] = '{-1, 0, -1, 1, -1, 2,
                   -1, 3, -1, 0};
    logic [N-1:0] eg;
    do_reset();
    bus.req      = 4'hF;
    bus.req_last = 4'hF;
    for (int i = 0; i < N; i++)
      set_data(i, 8'(8'h10 + i));
    for (int c = 0; c < 10; c++) begin
      eg = (eo[c] >= 0) ? 4'(1 << eo[c]) : 4'b0;
      #4;
      total_cnt++;
      if ({bus.gnt, bus.fifo_wr_en} !==
          {eg, (eo[c] >= 0)})
        $display("FAIL rr_order_c%0d: got gnt=%b en=%b want gnt=%b",
                 c, bus.gnt, bus.fifo_wr_en, eg);
      else pass_cnt++;
      if (eo[c] >= 0) begin
        total_cnt++;
        if ({bus.owner, bus.fifo_wr_data} !==
            {2'(eo[c]), 8'(8'h10 + eo[c])})
          $display("FAIL rr_word_c%0d: got owner=%0d data=%h want owner=%0d",
                   c, bus.owner, bus.fifo_wr_data,
                   eo[c]);
        else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_full_stall();
    logic [0:10] full_t = 11'b00011111000;
    logic [0:10] en_t   = 11'b01100000110;
    logic [0:10] busy_t = 11'b01111111110;
    int w = 0;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      bus.req  = (w < 4) ? 4'b0010 : 4'b0000;
      bus.full = full_t[c];
      set_data(1, 8'(8'hB0 + w));
      #4;
      total_cnt++;
      if ({bus.gnt, bus.fifo_wr_en, bus.busy} !==
          {(en_t[c] ? 4'b0010 : 4'b0000),
           en_t[c], busy_t[c]})
        $display("FAIL stall_c%0d: got gnt=%b en=%b busy=%b want en=%b busy=%b",
                 c, bus.gnt, bus.fifo_wr_en,
                 bus.busy, en_t[c], busy_t[c]);
      else pass_cnt++;
      if (c > 0) begin
        total_cnt++;
        if (bus.owner !== 2'd1)
          $display("FAIL stall_owner_c%0d: got %0d want 1",
                   c, bus.owner);
        else pass_cnt++;
      end
      if (en_t[c]) begin
        total_cnt++;
        if (bus.fifo_wr_data !== 8'(8'hB0 + w))
          $display("FAIL stall_data_c%0d: got %h want %h",
                   c, bus.fifo_wr_data,
                   8'(8'hB0 + w));
        else pass_cnt++;
      end
      tick();
      if (en_t[c]) w++;
    end
    bus.full = 1'b0;
  endtask

  task automatic test_withdraw();
    do_reset();
    bus.req      = 4'b0010;
    bus.req_last = 4'b0010;
    set_data(1, 8'hC1);
    tick();
    #4;
    total_cnt++;
    if (bus.gnt !== 4'b0010)
      $display("FAIL wd_first_gnt: got %b want 0010",
               bus.gnt);
    else pass_cnt++;
    tick();
    bus.req      = 4'b1000;
    bus.req_last = 4'b0000;
    set_data(3, 8'hD3);
    tick();
    #4;
    total_cnt++;
    if ({bus.gnt, bus.owner, bus.fifo_wr_data} !==
        {4'b1000, 2'd3, 8'hD3})
      $display("FAIL wd_owner3: got gnt=%b owner=%0d data=%h want 1000/3/d3",
               bus.gnt, bus.owner, bus.fifo_wr_data);
    else pass_cnt++;
    tick();
    bus.req = 4'b0101;
    #4;
    total_cnt++;
    if ({bus.gnt, bus.fifo_wr_en, bus.busy,
         bus.owner} !== {4'b0, 1'b0, 1'b1, 2'd3})
      $display("FAIL wd_drop: got gnt=%b en=%b busy=%b owner=%0d want 0/0/1/3",
               bus.gnt, bus.fifo_wr_en, bus.busy,
               bus.owner);
    else pass_cnt++;
    tick();
    #4;
    total_cnt++;
    if ({bus.busy, bus.owner} !== {1'b0, 2'd3})
      $display("FAIL wd_idle: got busy=%b owner=%0d want 0/3",
               bus.busy, bus.owner);
    else pass_cnt++;
    tick();
    #4;
    total_cnt++;
    if ({bus.gnt, bus.owner} !== {4'b0001, 2'd0})
      $display("FAIL wd_next: got gnt=%b owner=%0d want 0001/0",
               bus.gnt, bus.owner);
    else pass_cnt++;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req = 4'b0100;
    set_data(2, 8'hE0);
    tick();
    tick();
    set_data(2, 8'hE1);
    rst     = 1'b1;
    bus.req = 4'b0101;
    #4;
    total_cnt++;
    if ({bus.gnt, bus.fifo_wr_en,
         bus.fifo_wr_data} !==
        {4'b0100, 1'b1, 8'hE1})
      $display("FAIL rstmid_word: got gnt=%b en=%b data=%h want 0100/1/e1",
               bus.gnt, bus.fifo_wr_en,
               bus.fifo_wr_data);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    #4;
    total_cnt++;
    if ({bus.gnt, bus.fifo_wr_en, bus.busy,
         bus.owner} !== '0)
      $display("FAIL rstmid_clear: got gnt=%b en=%b busy=%b owner=%0d want all 0",
               bus.gnt, bus.fifo_wr_en, bus.busy,
               bus.owner);
    else pass_cnt++;
    tick();
    #4;
    total_cnt++;
    if ({bus.gnt, bus.owner} !== {4'b0001, 2'd0})
      $display("FAIL rstmid_prio: got gnt=%b owner=%0d want 0001/0",
               bus.gnt, bus.owner);
    else pass_cnt++;
    tick();
    clear_inputs();
  endtask

  task automatic test_soak();
    int wt[N];
    int bw = 0;
    logic [N-1:0] g;
    do_reset();
    for (int i = 0; i < N; i++) wt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++)
        if (!bus.req[i] &&
            $urandom_range(0, 3) == 0) begin
          bus.req[i]      = 1'b1;
          bus.req_last[i] =
            ($urandom_range(0, 3) == 0);
          set_data(i, 8'($urandom));
        end
      bus.full = ($urandom_range(0, 3) == 0);
      #4;
      g = bus.gnt;
      total_cnt++;
      if (!$onehot0(g) || bus.fifo_wr_en !== |g)
        $display("FAIL soak_onehot_c%0d: got gnt=%b en=%b",
                 c, g, bus.fifo_wr_en);
      else pass_cnt++;
      total_cnt++;
      if (bus.fifo_wr_en && bus.full)
        $display("FAIL soak_full_c%0d: got en=1 want 0 while full",
                 c);
      else pass_cnt++;
      if (|g) begin
        total_cnt++;
        if (g !== 4'(1 << bus.owner) ||
            bus.fifo_wr_data !==
            bus.req_data[int'(bus.owner)*DW +: DW])
          $display("FAIL soak_word_c%0d: got gnt=%b owner=%0d data=%h",
                   c, g, bus.owner, bus.fifo_wr_data);
        else pass_cnt++;
      end
      if (!bus.busy) bw = 0;
      else if (|g) bw++;
      total_cnt++;
      if (bw > MB)
        $display("FAIL soak_burst_c%0d: got %0d words want <= %0d",
                 c, bw, MB);
      else pass_cnt++;
      // wt counts the request cycle, so the gap is wt-1.
      for (int i = 0; i < N; i++) begin
        if (bus.busy && int'(bus.owner) == i)
          wt[i] = 0;
        else if (!bus.req[i])
          wt[i] = 0;
        else if (!bus.full)
          wt[i]++;
        total_cnt++;
        if (wt[i] - 1 > BOUND)
          $display("FAIL soak_wait_r%0d_c%0d: got %0d want <= %0d",
                   i, c, wt[i] - 1, BOUND);
        else pass_cnt++;
      end
      tick();
      for (int i = 0; i < N; i++)
        if (g[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.req[i]      = 1'b0;
            bus.req_last[i] = 1'b0;
          end else begin
            bus.req_last[i] =
              ($urandom_range(0, 3) == 0);
            set_data(i, 8'($urandom));
          end
        end
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_all_four();
    test_full_stall();
    test_withdraw();
    test_reset_mid();
    test_soak();
    $display("%0d/%0d checks passed",
             pass_cnt, total_cnt);
    $finish;
  end

endmodule
